rx_arbiter_queue: RTL

- Parametrised receive-side block for an interconnect node; successor to the three-input receiver queue.
- Buffers words from NCH source channels (e.g. left, right, self) in per-channel FIFOs.
- Merges the channels onto one output through a round-robin arbiter with a valid/ready handshake.
- Replaces single-shot "new" flags and a blind cycler: no word is lost, and back-pressure is supported.

---
 rtl/rx_arbiter_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rx_arbiter_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rx_arbiter_queue
//  Function : Receive-side queue for an interconnect node. Each of NCH input
//             channels feeds its own FIFO. A round-robin arbiter merges the
//             FIFOs onto one registered output with a valid/ready handshake.
//  Option   : RX_ARB_SKIP_EMPTY_EN
//               defined   -> work-conserving arbiter that skips empty channels
//               undefined -> legacy cycler; the pointer advances on every clock
//                            and only channel rr may be granted
//  Revision : 1.0  initial release
// ============================================================================
module rx_arbiter_queue #(
    parameter int WIDTH = 32,
    parameter int NCH   = 3,
    parameter int DEPTH = 4,
    parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_src
);

    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam int                c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    // Per-channel views exported from the FIFO generate blocks
    logic [c_cnt_w-1:0] w_count [NCH];
    logic [WIDTH-1:0]   w_head  [NCH];

    // Arbitration results
    logic               w_load;
    logic               w_grant_vld;
    logic [SEL_W-1:0]   w_grant;
    logic               w_fire;

    logic [SEL_W-1:0]   r_rr;

    // Wrap-around increment of a channel index
    function automatic logic [SEL_W-1:0] f_next(input logic [SEL_W-1:0] v);
        return (v == SEL_W'(NCH - 1)) ? '0 : v + SEL_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NCH; c++) begin : g_fifo
        logic [WIDTH-1:0]   r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_cnt_w-1:0] r_count;
        logic               w_push;
        logic               w_pop;

        // Ready depends only on the registered count; held low in reset
        assign in_ready[c] = rst_n && (r_count != c_full);
        assign w_push      = in_valid[c] && in_ready[c];
        assign w_pop       = w_fire && (w_grant == SEL_W'(c));
        assign w_count[c]  = r_count;
        assign w_head[c]   = r_mem[r_rd_ptr];

        // Storage array; contents are don't-care while the count is zero
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[c*WIDTH +: WIDTH];
            end
        end

        // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_w'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------------
    assign w_load = !out_valid || out_ready;
    assign w_fire = w_load && w_grant_vld;

`ifdef RX_ARB_SKIP_EMPTY_EN
    logic [SEL_W:0] w_scan_sum;
    logic [SEL_W-1:0] w_scan_idx;

    // Pick the first non-empty channel starting at rr. The scan runs from the
    // farthest candidate inward so the nearest non-empty channel wins.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_scan_sum = {1'b0, r_rr} + (SEL_W+1)'(k);
            if (w_scan_sum >= (SEL_W+1)'(NCH)) begin
                w_scan_sum = w_scan_sum - (SEL_W+1)'(NCH);
            end
            w_scan_idx = w_scan_sum[SEL_W-1:0];
            if (w_count[w_scan_idx] != '0) begin
                w_grant     = w_scan_idx;
                w_grant_vld = 1'b1;
            end
        end
    end

    // Granted channel drops to lowest priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (w_fire) begin
            r_rr <= f_next(w_grant);
        end
    end
`else
    // Only the channel under the cycling pointer is a candidate
    always_comb begin
        w_grant     = r_rr;
        w_grant_vld = (w_count[r_rr] != '0);
    end

    // Cycling pointer advances every clock regardless of grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else begin
            r_rr <= f_next(r_rr);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Output register stage; holds its word while the consumer stalls
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (w_load) begin
            if (w_grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= w_head[w_grant];
                out_src   <= w_grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
